// File: rtl/cache_line_mem_master.sv
// Line-level memory master: optional dirty writeback, then optional fill.
// Ports: fill_req/wb_req command in, mem_* word bus out, busy/done/fill_line status.
module cache_line_mem_master #(
   parameter int WORDS_PER_LINE = 4,
   parameter int ADDR_W         = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         fill_req,
   input  logic                         wb_req,
   input  logic [ADDR_W-1:0]            fill_addr,
   input  logic [ADDR_W-1:0]            wb_addr,
   input  logic [32*WORDS_PER_LINE-1:0] wb_line,
   output logic                         busy,
   output logic                         done,
   output logic [32*WORDS_PER_LINE-1:0] fill_line,
   output logic                         mem_read,
   output logic                         mem_write,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata,
   input  logic                         mem_ready
);

   localparam int OFS = $clog2(4*WORDS_PER_LINE);
   localparam int IW  = $clog2(WORDS_PER_LINE);
   localparam int LW  = 32*WORDS_PER_LINE;

   typedef enum logic [2:0] {
      IDLE,
      WB_ISSUE,
      WB_WAIT,
      RD_ISSUE,
      RD_WAIT,
      DONE
   } state_t;

   state_t              r_state;
   logic [IW-1:0]       r_idx;
   logic [ADDR_W-1:0]   r_wb_base;
   logic [ADDR_W-1:0]   r_fill_base;
   logic                r_fill_pend;
   logic [LW-1:0]       r_wb_line;
   logic [LW-1:0]       r_fill_line;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;

   logic [IW-1:0]       w_idx_nx;
   logic                w_last;
   logic [ADDR_W-1:0]   w_wb_base;
   logic [ADDR_W-1:0]   w_fill_base;
   logic [ADDR_W-1:0]   w_ofs_nx;
   logic [IW+4:0]       w_sel_cur;
   logic [IW+4:0]       w_sel_nx;
   logic                w_unused_ofs;

   assign w_idx_nx    = r_idx + 1'b1;
   assign w_last      = (r_idx == IW'(WORDS_PER_LINE-1));
   assign w_wb_base   = {wb_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
   assign w_fill_base = {fill_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
   assign w_ofs_nx    = ADDR_W'({w_idx_nx, 2'b00});
   assign w_sel_cur   = {r_idx, 5'b00000};
   assign w_sel_nx    = {w_idx_nx, 5'b00000};
   // Line-offset address bits are deliberately discarded.
   assign w_unused_ofs = ^{wb_addr[OFS-1:0], fill_addr[OFS-1:0]};

   // Strobes and status decode straight from the state register.
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign mem_write = (r_state == WB_ISSUE);
   assign mem_read  = (r_state == RD_ISSUE);
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign fill_line = r_fill_line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_wb_base   <= '0;
         r_fill_base <= '0;
         r_fill_pend <= 1'b0;
         r_wb_line   <= '0;
         r_fill_line <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_idx <= '0;
               if (wb_req) begin
                  r_state     <= WB_ISSUE;
                  r_wb_line   <= wb_line;
                  r_wb_base   <= w_wb_base;
                  r_fill_pend <= fill_req;
                  r_fill_base <= w_fill_base;
                  r_mem_addr  <= w_wb_base;
                  r_mem_wdata <= wb_line[31:0];
                  if (fill_req)
                     r_fill_line <= '0;
               end else if (fill_req) begin
                  r_state     <= RD_ISSUE;
                  r_fill_pend <= 1'b0;
                  r_fill_base <= w_fill_base;
                  r_mem_addr  <= w_fill_base;
                  r_fill_line <= '0;
               end
            end
            WB_ISSUE: r_state <= WB_WAIT;
            WB_WAIT: begin
               if (mem_ready) begin
                  if (w_last) begin
                     r_idx <= '0;
                     if (r_fill_pend) begin
                        r_state    <= RD_ISSUE;
                        r_mem_addr <= r_fill_base;
                     end else begin
                        r_state <= DONE;
                     end
                  end else begin
                     r_idx       <= w_idx_nx;
                     r_mem_addr  <= r_wb_base + w_ofs_nx;
                     r_mem_wdata <= r_wb_line[w_sel_nx +: 32];
                     r_state     <= WB_ISSUE;
                  end
               end
            end
            RD_ISSUE: r_state <= RD_WAIT;
            RD_WAIT: begin
               if (mem_ready) begin
                  r_fill_line[w_sel_cur +: 32] <= mem_rdata;
                  if (w_last) begin
                     r_idx   <= '0;
                     r_state <= DONE;
                  end else begin
                     r_idx      <= w_idx_nx;
                     r_mem_addr <= r_fill_base + w_ofs_nx;
                     r_state    <= RD_ISSUE;
                  end
               end
            end
            DONE: begin
               r_fill_pend <= 1'b0;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_mem_master.sv
// Scoreboard bench for cache_line_mem_master.
// Expected bus words and done events are queued by stimulus, checked by a monitor.
module tb_cache_line_mem_master;

   localparam int LW = 128;

   localparam logic [31:0] A0 = 32'hA000_0100, A1 = 32'hA111_0104;
   localparam logic [31:0] A2 = 32'hA222_0108, A3 = 32'hA333_010C;
   localparam logic [31:0] B0 = 32'hB000_0400, B1 = 32'hB111_0404;
   localparam logic [31:0] B2 = 32'hB222_0408, B3 = 32'hB333_040C;
   localparam logic [31:0] C0 = 32'hC000_0300, C1 = 32'hC111_0304;
   localparam logic [31:0] C2 = 32'hC222_0308, C3 = 32'hC333_030C;
   localparam logic [31:0] D0 = 32'hD000_0001, D1 = 32'hD111_0002;
   localparam logic [31:0] D2 = 32'hD222_0003, D3 = 32'hD333_0004;
   localparam logic [31:0] E0 = 32'hE000_1000, E1 = 32'hE111_2000;
   localparam logic [31:0] E2 = 32'hE222_3000, E3 = 32'hE333_4000;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           fill_req = 1'b0;
   logic           wb_req = 1'b0;
   logic [31:0]    fill_addr = '0;
   logic [31:0]    wb_addr = '0;
   logic [LW-1:0]  wb_line = '0;
   logic           busy, done, mem_read, mem_write;
   logic [LW-1:0]  fill_line;
   logic [31:0]    mem_addr, mem_wdata;
   logic [31:0]    mem_rdata = '0;
   logic           mem_ready = 1'b0;

   cache_line_mem_master #(.WORDS_PER_LINE(4), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .fill_req(fill_req), .wb_req(wb_req),
      .fill_addr(fill_addr), .wb_addr(wb_addr), .wb_line(wb_line),
      .busy(busy), .done(done), .fill_line(fill_line),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } bus_t;

   typedef struct {
      int          cyc;
      logic [LW-1:0] line;
   } done_t;

   bus_t        exp_bus[$];
   done_t       exp_done[$];
   int          inj[$];
   logic [31:0] mem [int];
   int          lat = 1;
   int          cnt = 0;
   logic [31:0] rd_addr = '0;
   int          n_checks = 0;
   int          n_fail = 0;
   bit          done_seen = 0;
   bit          prev_strobe = 0;
   int          t0;

   task automatic chk(input string nm, input logic [LW-1:0] act,
                      input logic [LW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic push_line(input bit wr, input logic [31:0] base,
                            input logic [LW-1:0] data);
      bus_t b;
      for (int i = 0; i < 4; i++) begin
         b.wr   = wr;
         b.addr = base + 32'(4*i);
         b.data = data[32*i +: 32];
         exp_bus.push_back(b);
      end
   endtask

   task automatic push_done(input int c, input logic [LW-1:0] line);
      done_t d;
      d.cyc  = c;
      d.line = line;
      exp_done.push_back(d);
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (!done_seen && n < max) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (!done_seen) begin
         n_fail++;
         $display("FAIL done_timeout: got no done in %0d cycles, required done", max);
      end
      @(negedge clk);
   endtask

   task automatic chk_drained(input string nm);
      chk({nm, "_bus_left"}, LW'(exp_bus.size()), '0);
      chk({nm, "_done_left"}, LW'(exp_done.size()), '0);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, LW'(busy), '0);
      chk({nm, "_done"}, LW'(done), '0);
      chk({nm, "_rd"}, LW'(mem_read), '0);
      chk({nm, "_wr"}, LW'(mem_write), '0);
      chk({nm, "_addr"}, LW'(mem_addr), '0);
      chk({nm, "_wdata"}, LW'(mem_wdata), '0);
      chk({nm, "_line"}, fill_line, '0);
   endtask

   // Memory model: ready arrives lat cycles after the strobe.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            cnt = 0;
            mem_ready = 1'b0;
            mem_rdata = '0;
         end else begin
            mem_ready = (cnt == 1);
            mem_rdata = '0;
            if (cnt == 1 && mem.exists(int'(rd_addr)))
               mem_rdata = mem[int'(rd_addr)];
            if (cnt > 0) cnt--;
            while (inj.size() > 0 && inj[0] < cyc)
               void'(inj.pop_front());
            if (inj.size() > 0 && inj[0] == cyc) begin
               void'(inj.pop_front());
               if (!mem_ready) begin
                  mem_ready = 1'b1;
                  mem_rdata = 32'hDEAD_BEEF;
               end
            end
            if (mem_write) mem[int'(mem_addr)] = mem_wdata;
            if (mem_read || mem_write) begin
               rd_addr = mem_addr;
               cnt = lat;
            end
         end
      end
   end

   // Monitor
   initial begin
      bus_t  b;
      done_t d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (mem_read || mem_write) begin
               chk("strobe_excl", LW'(mem_read & mem_write), '0);
               chk("strobe_width", LW'(prev_strobe), '0);
               if (exp_bus.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL bus_unexpected: got rd=%0b wr=%0b addr %0h, required no access",
                           mem_read, mem_write, mem_addr);
               end else begin
                  b = exp_bus.pop_front();
                  chk("bus_write", LW'(mem_write), LW'(b.wr));
                  chk("bus_addr", LW'(mem_addr), LW'(b.addr));
                  if (b.wr) chk("bus_wdata", LW'(mem_wdata), LW'(b.data));
               end
            end
            if (done) begin
               done_seen = 1;
               if (exp_done.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
               end else begin
                  d = exp_done.pop_front();
                  chk("done_cycle", LW'(cyc), LW'(d.cyc));
                  chk("done_line", fill_line, d.line);
                  chk("done_busy", LW'(busy), LW'(1));
               end
            end
         end
         prev_strobe = rst_n && (mem_read || mem_write);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got simulation time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      mem[32'h100] = A0; mem[32'h104] = A1;
      mem[32'h108] = A2; mem[32'h10C] = A3;
      mem[32'h300] = C0; mem[32'h304] = C1;
      mem[32'h308] = C2; mem[32'h30C] = C3;
      mem[32'h400] = B0; mem[32'h404] = B1;
      mem[32'h408] = B2; mem[32'h40C] = B3;

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("post_reset");

      // Fill-only, unaligned address
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 32'h104;
      t0 = cyc; done_seen = 0;
      push_line(1'b0, 32'h100, '0);
      push_done(t0 + 9, {A3, A2, A1, A0});
      @(negedge clk);
      fill_req = 1'b0;
      chk("fill_busy_c1", LW'(busy), LW'(1));
      wait_done(40);
      chk("fill_idle_busy", LW'(busy), '0);
      chk_drained("fill");

      // Writeback-only; fill_line must stay at the previous fill
      @(negedge clk);
      wb_req = 1'b1; wb_addr = 32'h200; wb_line = {D3, D2, D1, D0};
      t0 = cyc; done_seen = 0;
      push_line(1'b1, 32'h200, {D3, D2, D1, D0});
      push_done(t0 + 9, {A3, A2, A1, A0});
      @(negedge clk);
      wb_req = 1'b0; wb_line = '0;
      wait_done(40);
      chk_drained("wb");

      // Combined writeback then fill
      @(negedge clk);
      wb_req = 1'b1; fill_req = 1'b1;
      wb_addr = 32'h200; fill_addr = 32'h300; wb_line = {E3, E2, E1, E0};
      t0 = cyc; done_seen = 0;
      push_line(1'b1, 32'h200, {E3, E2, E1, E0});
      push_line(1'b0, 32'h300, '0);
      push_done(t0 + 17, {C3, C2, C1, C0});
      @(negedge clk);
      wb_req = 1'b0; fill_req = 1'b0; wb_line = '0;
      wait_done(60);
      chk_drained("combo");
      chk("combo_mem_e3", LW'(mem[32'h20C]), LW'(E3));

      // Stalled memory, spurious ready, requests while busy
      lat = 3;
      @(negedge clk);
      inj.push_back(cyc + 1);
      inj.push_back(cyc + 2);
      inj.push_back(cyc + 6);
      inj.push_back(cyc + 18);
      inj.push_back(cyc + 19);
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 32'h10C;
      t0 = cyc; done_seen = 0;
      push_line(1'b0, 32'h100, '0);
      push_done(t0 + 17, {A3, A2, A1, A0});
      @(negedge clk);
      fill_req = 1'b0;
      repeat (2) @(negedge clk);
      wb_req = 1'b1; fill_req = 1'b1;
      wb_addr = 32'h500; fill_addr = 32'h600; wb_line = {4{32'h5555_AAAA}};
      @(negedge clk);
      wb_req = 1'b0; fill_req = 1'b0;
      while (cyc < t0 + 17) @(negedge clk);
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      repeat (6) @(negedge clk);
      chk("stall_done_seen", LW'(done_seen), LW'(1));
      chk("stall_idle_busy", LW'(busy), '0);
      chk_drained("stall");
      lat = 1;

      // Reset during RD_WAIT of word 2
      @(negedge clk);
      fill_req = 1'b1; fill_addr = 32'h400;
      t0 = cyc; done_seen = 0;
      push_line(1'b0, 32'h400, '0);
      push_done(t0 + 9, {B3, B2, B1, B0});
      @(negedge clk);
      fill_req = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_reset_pending", LW'(exp_bus.size()), LW'(1));
      chk("pre_reset_busy", LW'(busy), LW'(1));
      rst_n = 1'b0;
      #1;
      chk_all_zero("midop_reset");
      exp_bus.delete();
      exp_done.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_reset_busy", LW'(busy), '0);

      @(negedge clk);
      fill_req = 1'b1; fill_addr = 32'h408;
      t0 = cyc; done_seen = 0;
      push_line(1'b0, 32'h400, '0);
      push_done(t0 + 9, {B3, B2, B1, B0});
      @(negedge clk);
      fill_req = 1'b0;
      wait_done(40);
      chk_drained("refill");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
